// File: rtl/boot_pkg.sv
// Shared definitions for the PROM boot copier.
//   PROM_AW : PROM word-address width (4 KB PROM, 1024 words)
//   RAM_AW  : RAM word-address width
//   DW      : data width of both buses
//   state_e : copier FSM states
package boot_pkg;

  localparam int unsigned PROM_AW = 10;
  localparam int unsigned RAM_AW  = 22;
  localparam int unsigned DW      = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/boot_ack_edge.sv
// Completion detector for the toggle-ack PROM port.
// The PROM ack toggles once per strobed cycle and then holds, so a read completes only on a
// fresh 0->1 edge; a level that is still high from the previous read is ignored.
//   i_clk   : system clock
//   i_rst   : synchronous reset, active-low
//   i_ack   : PROM ack
//   i_stb   : a read is outstanding (copier is in its read state)
//   o_pulse : one-cycle read completion
module boot_ack_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ack,
  input  logic i_stb,
  output logic o_pulse
);

  logic r_ack_q;

  // Registered every cycle, independent of the strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ack_q <= 1'b0;
    end else begin
      r_ack_q <= i_ack;
    end
  end

  assign o_pulse = i_stb & i_ack & ~r_ack_q;

endmodule

// File: rtl/prom_boot_copier.sv
// Boot copier: after reset, reads NWORDS words from the PROM (word 0 upward), writes each to
// RAM starting at RAM_BASE, keeps a mod-2^32 checksum and releases the CPU when finished.
// Any handshake that waits TIMEOUT cycles without completing parks the copier in ERR.
//   i_clk, i_rst          : clock, synchronous active-low reset
//   o_prom_stb/we/addr    : PROM request (we always 0)
//   i_prom_data/ack       : PROM read data, toggle-style ack
//   o_ram_stb/we/addr/data: RAM write request
//   i_ram_ack             : RAM level ack
//   o_cpu_hold            : hold CPU until the copy completes
//   o_done / o_error      : sticky status
//   o_checksum            : running sum of copied words
module prom_boot_copier
  import boot_pkg::*;
#(
  parameter int unsigned        NWORDS   = 1024,
  parameter logic [RAM_AW-1:0]  RAM_BASE = '0,
  parameter int unsigned        TIMEOUT  = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_prom_stb,
  output logic               o_prom_we,
  output logic [PROM_AW-1:0] o_prom_addr,
  input  logic [DW-1:0]      i_prom_data,
  input  logic               i_prom_ack,
  output logic               o_ram_stb,
  output logic               o_ram_we,
  output logic [RAM_AW-1:0]  o_ram_addr,
  output logic [DW-1:0]      o_ram_data,
  input  logic               i_ram_ack,
  output logic               o_cpu_hold,
  output logic               o_done,
  output logic               o_error,
  output logic [DW-1:0]      o_checksum
);

  localparam logic [PROM_AW-1:0] IdxLast   = PROM_AW'(NWORDS - 1);
  localparam logic [7:0]         TimeoutM1 = 8'(TIMEOUT - 1);

  state_e             r_state;
  state_e             w_state_d;
  logic [PROM_AW-1:0] r_idx;
  logic [7:0]         r_wait;
  logic [DW-1:0]      r_ram_data;
  logic [DW-1:0]      r_checksum;

  logic w_in_rd;
  logic w_rd_done;
  logic w_wr_done;
  logic w_last;
  logic w_tmo;

  assign w_in_rd   = (r_state == RD);
  assign w_wr_done = (r_state == WR) & i_ram_ack;
  assign w_last    = (r_idx == IdxLast);
  assign w_tmo     = (r_wait == TimeoutM1);

  boot_ack_edge u_ack_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_ack  (i_prom_ack),
    .i_stb  (w_in_rd),
    .o_pulse(w_rd_done)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: w_state_d = RD;
      RD: begin
        if (w_rd_done) begin
          w_state_d = WR;
        end else if (w_tmo) begin
          w_state_d = ERR;
        end
      end
      WR: begin
        if (w_wr_done) begin
          w_state_d = w_last ? DONE : RD;
        end else if (w_tmo) begin
          w_state_d = ERR;
        end
      end
      DONE:    w_state_d = DONE;
      ERR:     w_state_d = ERR;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_wait     <= '0;
      r_ram_data <= '0;
      r_checksum <= '0;
    end else begin
      r_state <= w_state_d;
      // Every state change is an entry into RD/WR or into an absorbing state.
      if (w_state_d != r_state) begin
        r_wait <= '0;
      end else if (w_in_rd || (r_state == WR)) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_rd_done) begin
        r_ram_data <= i_prom_data;
        r_checksum <= r_checksum + i_prom_data;
      end
      // Terminal check precedes the increment, so idx never wraps.
      if (w_wr_done && !w_last) begin
        r_idx <= r_idx + PROM_AW'(1);
      end
    end
  end

  // Strobe drops in the completion cycle so the PROM ack does not toggle again.
  assign o_prom_stb  = w_in_rd & ~w_rd_done;
  assign o_prom_we   = 1'b0;
  assign o_prom_addr = r_idx;
  assign o_ram_stb   = (r_state == WR);
  assign o_ram_we    = (r_state == WR);
  assign o_ram_addr  = RAM_BASE + RAM_AW'(r_idx);
  assign o_ram_data  = r_ram_data;
  assign o_cpu_hold  = (r_state != DONE);
  assign o_done      = (r_state == DONE);
  assign o_error     = (r_state == ERR);
  assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_prom_boot_copier.sv
`timescale 1ns/1ps
module tb_prom_boot_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: NWORDS=4, TIMEOUT=8, RAM_BASE=0 ----------------
  logic        a_rst, a_pm_rst;
  logic        a_prom_stb, a_prom_we, a_prom_ack;
  logic [9:0]  a_prom_addr;
  logic [31:0] a_prom_data;
  logic        a_ram_stb, a_ram_we, a_ram_ack;
  logic [21:0] a_ram_addr;
  logic [31:0] a_ram_data, a_checksum;
  logic        a_cpu_hold, a_done, a_error;

  prom_boot_copier #(.NWORDS(4), .RAM_BASE(22'h0), .TIMEOUT(8)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst),
    .o_prom_stb(a_prom_stb), .o_prom_we(a_prom_we), .o_prom_addr(a_prom_addr),
    .i_prom_data(a_prom_data), .i_prom_ack(a_prom_ack),
    .o_ram_stb(a_ram_stb), .o_ram_we(a_ram_we), .o_ram_addr(a_ram_addr),
    .o_ram_data(a_ram_data), .i_ram_ack(a_ram_ack),
    .o_cpu_hold(a_cpu_hold), .o_done(a_done), .o_error(a_error), .o_checksum(a_checksum)
  );

  // PROM model: mem[i] = i+1, ack toggles on each strobed cycle and holds otherwise.
  always @(posedge clk) begin
    if (!a_pm_rst) a_prom_ack <= 1'b0;
    else if (a_prom_stb) a_prom_ack <= ~a_prom_ack;
  end
  assign a_prom_data = 32'(a_prom_addr) + 32'd1;

  // RAM model: ack after a_ram_wait strobed cycles.
  int a_ram_wait;
  int a_rcnt;
  assign a_ram_ack = a_ram_stb && (a_rcnt >= a_ram_wait);
  always @(posedge clk) begin
    if (!a_ram_stb || a_ram_ack) a_rcnt <= 0;
    else a_rcnt <= a_rcnt + 1;
  end

  // Edge counter since reset release; monitors sample on the falling edge.
  int          a_cyc;
  int          a_nw;
  logic [21:0] a_wa [0:15];
  logic [31:0] a_wd [0:15];
  int          a_wt [0:15];
  int          a_overlap, a_webad, a_unstable;
  logic        a_pstb;
  logic [21:0] a_paddr;
  logic [31:0] a_pdata;

  always @(posedge clk) begin
    if (!a_rst) a_cyc <= 0;
    else a_cyc <= a_cyc + 1;
  end

  always @(negedge clk) begin
    if (!a_rst) begin
      a_nw <= 0;
    end else if (a_ram_stb && a_ram_ack && a_nw < 16) begin
      a_wa[a_nw] <= a_ram_addr;
      a_wd[a_nw] <= a_ram_data;
      a_wt[a_nw] <= a_cyc + 1;  // edge at which the write is accepted
      a_nw       <= a_nw + 1;
    end
    if (a_prom_stb && a_ram_stb) a_overlap <= a_overlap + 1;
    if (a_ram_stb && !a_ram_we) a_webad <= a_webad + 1;
    if (a_pstb && a_ram_stb && (a_ram_addr != a_paddr || a_ram_data != a_pdata))
      a_unstable <= a_unstable + 1;
    a_pstb  <= a_ram_stb && !a_ram_ack;
    a_paddr <= a_ram_addr;
    a_pdata <= a_ram_data;
  end

  // ---------------- DUT B: NWORDS=1024, RAM_BASE=3FFF00 ----------------
  logic        b_rst, b_pm_rst;
  logic        b_prom_stb, b_prom_we, b_prom_ack;
  logic [9:0]  b_prom_addr;
  logic [31:0] b_prom_data;
  logic        b_ram_stb, b_ram_we, b_ram_ack;
  logic [21:0] b_ram_addr;
  logic [31:0] b_ram_data, b_checksum;
  logic        b_cpu_hold, b_done, b_error;

  prom_boot_copier #(.NWORDS(1024), .RAM_BASE(22'h3FFF00), .TIMEOUT(255)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .o_prom_stb(b_prom_stb), .o_prom_we(b_prom_we), .o_prom_addr(b_prom_addr),
    .i_prom_data(b_prom_data), .i_prom_ack(b_prom_ack),
    .o_ram_stb(b_ram_stb), .o_ram_we(b_ram_we), .o_ram_addr(b_ram_addr),
    .o_ram_data(b_ram_data), .i_ram_ack(b_ram_ack),
    .o_cpu_hold(b_cpu_hold), .o_done(b_done), .o_error(b_error), .o_checksum(b_checksum)
  );

  always @(posedge clk) begin
    if (!b_pm_rst) b_prom_ack <= 1'b0;
    else if (b_prom_stb) b_prom_ack <= ~b_prom_ack;
  end
  assign b_prom_data = 32'(b_prom_addr) + 32'd1;
  assign b_ram_ack   = b_ram_stb;

  int          b_cyc;
  int          b_nw;
  logic [21:0] b_wa [0:1023];
  logic [31:0] b_wd [0:1023];
  int          b_overlap;

  always @(posedge clk) begin
    if (!b_rst) b_cyc <= 0;
    else b_cyc <= b_cyc + 1;
  end

  always @(negedge clk) begin
    if (!b_rst) begin
      b_nw <= 0;
    end else if (b_ram_stb && b_ram_ack && b_nw < 1024) begin
      b_wa[b_nw] <= b_ram_addr;
      b_wd[b_nw] <= b_ram_data;
      b_nw       <= b_nw + 1;
    end
    if (b_prom_stb && b_ram_stb) b_overlap <= b_overlap + 1;
  end

  // ---------------- helpers ----------------
  task automatic wait_a(input int budget);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!(a_done || a_error) && k < budget);
  endtask

  task automatic reset_a(input bit clr_model);
    a_rst = 1'b0;
    if (clr_model) a_pm_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_pm_rst = 1'b1;
    a_rst    = 1'b1;
  endtask

  task automatic check_a_image(input string tag);
    check_val({tag, "_nwrites"}, a_nw, 4);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("%s_addr%0d", tag, j), 32'(a_wa[j]), j);
      check_val($sformatf("%s_data%0d", tag, j), a_wd[j], j + 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b0; a_pm_rst = 1'b0; a_ram_wait = 0;
    b_rst = 1'b0; b_pm_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_val("rst_prom_stb", a_prom_stb, 0);
    check_val("rst_ram_stb", a_ram_stb, 0);
    check_val("rst_ram_we", a_ram_we, 0);
    check_val("rst_prom_we", a_prom_we, 0);
    check_val("rst_prom_addr", a_prom_addr, 0);
    check_val("rst_ram_addr", a_ram_addr, 0);
    check_val("rst_ram_data", a_ram_data, 0);
    check_val("rst_cpu_hold", a_cpu_hold, 1);
    check_val("rst_done", a_done, 0);
    check_val("rst_error", a_error, 0);
    check_val("rst_checksum", a_checksum, 0);

    // Zero-wait copy: 1+2+3*3+4 = 16 edges; write j accepted at edge 4+4j.
    a_pm_rst = 1'b1; a_rst = 1'b1;
    wait_a(100);
    check_val("t1_finished", a_done | a_error, 1);
    check_val("t1_done_cyc", a_cyc, 16);
    check_val("t1_done", a_done, 1);
    check_val("t1_error", a_error, 0);
    check_val("t1_cpu_hold", a_cpu_hold, 0);
    check_val("t1_checksum", a_checksum, 10);
    check_a_image("t1");
    for (int j = 0; j < 4; j++) check_val($sformatf("t1_wr_edge%0d", j), a_wt[j], 4 + 4 * j);
    repeat (3) @(posedge clk);
    #1;
    check_val("t1_done_sticky", a_done, 1);
    check_val("t1_done_prom_stb", a_prom_stb, 0);
    check_val("t1_done_ram_stb", a_ram_stb, 0);

    // RAM wait states: each write holds 4 cycles, so writes land at 7,14,21,28.
    a_ram_wait = 3;
    reset_a(1'b1);
    wait_a(200);
    check_val("t2_finished", a_done | a_error, 1);
    check_val("t2_done_cyc", a_cyc, 28);
    check_val("t2_checksum", a_checksum, 10);
    check_a_image("t2");
    for (int j = 0; j < 4; j++) check_val($sformatf("t2_wr_edge%0d", j), a_wt[j], 7 + 7 * j);

    // Timeout: RAM never acks; WR entered after edge 3, ERR after 8 WR cycles (edge 11).
    a_ram_wait = 100000;
    reset_a(1'b1);
    wait_a(100);
    check_val("t3_finished", a_done | a_error, 1);
    check_val("t3_err_cyc", a_cyc, 11);
    check_val("t3_error", a_error, 1);
    check_val("t3_done", a_done, 0);
    check_val("t3_cpu_hold", a_cpu_hold, 1);
    check_val("t3_prom_stb", a_prom_stb, 0);
    check_val("t3_ram_stb", a_ram_stb, 0);
    check_val("t3_checksum", a_checksum, 1);
    check_val("t3_ram_data", a_ram_data, 1);
    repeat (5) @(posedge clk);
    #1;
    check_val("t3_error_sticky", a_error, 1);
    check_val("t3_checksum_frozen", a_checksum, 1);

    // Reset mid-copy during the 3rd write (WR cycle after edge 11); PROM ack left stale.
    a_ram_wait = 0;
    reset_a(1'b1);
    repeat (11) @(posedge clk);
    #1;
    check_val("t4_in_wr3", a_ram_stb, 1);
    check_val("t4_wr3_addr", a_ram_addr, 2);
    check_val("t4_wr3_checksum", a_checksum, 6);
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("t4_rst_prom_stb", a_prom_stb, 0);
    check_val("t4_rst_ram_stb", a_ram_stb, 0);
    check_val("t4_rst_checksum", a_checksum, 0);
    check_val("t4_rst_prom_addr", a_prom_addr, 0);
    check_val("t4_rst_ram_data", a_ram_data, 0);
    check_val("t4_rst_cpu_hold", a_cpu_hold, 1);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    wait_a(100);
    check_val("t4_finished", a_done | a_error, 1);
    check_val("t4_done", a_done, 1);
    check_val("t4_checksum", a_checksum, 10);
    check_a_image("t4");

    check_val("a_strobe_overlap", a_overlap, 0);
    check_val("a_ram_we_low", a_webad, 0);
    check_val("a_ram_unstable", a_unstable, 0);

    // Full image: 1+2+3*1023+1024 = 4096 edges; destination wraps mod 2^22.
    b_pm_rst = 1'b1; b_rst = 1'b1;
    begin
      int k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!(b_done || b_error) && k < 6000);
    end
    check_val("b_finished", b_done | b_error, 1);
    check_val("b_done_cyc", b_cyc, 4096);
    check_val("b_done", b_done, 1);
    check_val("b_error", b_error, 0);
    check_val("b_cpu_hold", b_cpu_hold, 0);
    check_val("b_checksum", b_checksum, 524800);
    check_val("b_nwrites", b_nw, 1024);
    check_val("b_addr_first", 32'(b_wa[0]), 32'h3FFF00);
    check_val("b_addr_255", 32'(b_wa[255]), 32'h3FFFFF);
    check_val("b_addr_256", 32'(b_wa[256]), 32'h0);
    check_val("b_addr_last", 32'(b_wa[1023]), 32'h2FF);
    check_val("b_data_last", b_wd[1023], 1024);
    begin
      int bad = 0;
      logic [21:0] ea;
      for (int i = 0; i < 1024; i++) begin
        ea = 22'h3FFF00 + 22'(i);
        if (b_wa[i] !== ea || b_wd[i] !== 32'(i + 1)) bad++;
      end
      check_val("b_seq_errors", bad, 0);
    end
    check_val("b_strobe_overlap", b_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
